// File: rtl/softmax_row_seq.sv
// -----------------------------------------------------------------------------
// softmax_row_seq
//
// Row sequencer and initiator for the softmax unit in the MHA datapath.
// Accepts one score row at a time, holds it stable on the softmax inputs while
// the start level is high, captures the softmax result on its one-cycle valid
// pulse and presents the result row downstream on a valid/ready stream.
//
// Rows are flat vectors: element i occupies bits [i*D_W +: D_W].
//
// Ports
//   I_CLK, I_RST_N         clock, asynchronous active-low reset
//   I_ROW_VLD/O_ROW_RDY    input row handshake, I_ROW_DATA input row
//   O_SM_START, O_SM_DATA  softmax start level and held input row
//   I_SM_VLD, I_SM_DATA    softmax one-cycle result valid and result row
//   O_OUT_VLD/I_OUT_RDY    result row handshake
//   O_OUT_DATA/IDX/LAST    result row, its row index, last-row flag
//   O_DONE                 one-cycle pulse after the last row of a matrix
//   O_ERR                  sticky softmax timeout flag
// -----------------------------------------------------------------------------
module softmax_row_seq #(
    parameter int D_W     = 8,
    parameter int NUM     = 16,
    parameter int ROWS    = 16,
    parameter int TIMEOUT = 15,
    localparam int IDX_W  = $clog2(ROWS)
) (
    input  logic                 I_CLK,
    input  logic                 I_RST_N,
    input  logic                 I_ROW_VLD,
    output logic                 O_ROW_RDY,
    input  logic [NUM*D_W-1:0]   I_ROW_DATA,
    output logic                 O_SM_START,
    output logic [NUM*D_W-1:0]   O_SM_DATA,
    input  logic                 I_SM_VLD,
    input  logic [NUM*D_W-1:0]   I_SM_DATA,
    output logic                 O_OUT_VLD,
    input  logic                 I_OUT_RDY,
    output logic [NUM*D_W-1:0]   O_OUT_DATA,
    output logic [IDX_W-1:0]     O_OUT_IDX,
    output logic                 O_OUT_LAST,
    output logic                 O_DONE,
    output logic                 O_ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
    localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

    state_t               state_reg;
    logic [7:0]           to_cnt_reg;
    logic [IDX_W-1:0]     row_cnt_reg;
    logic                 timed_out_reg;   // selects S_GAP exit: S_IDLE vs S_OUT
    logic                 sm_start_reg;
    logic [NUM*D_W-1:0]   row_buf_reg;
    logic [NUM*D_W-1:0]   res_buf_reg;
    logic                 out_vld_reg;
    logic [IDX_W-1:0]     out_idx_reg;
    logic                 out_last_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic [IDX_W-1:0]     row_cnt_next;

    // Row counter wraps explicitly so non-power-of-two ROWS works.
    assign row_cnt_next = (row_cnt_reg == LAST_IDX) ? '0 : row_cnt_reg + 1'b1;

    // Gated with reset so the upstream never sees ready while held in reset.
    assign O_ROW_RDY  = I_RST_N && (state_reg == S_IDLE);
    assign O_SM_START = sm_start_reg;
    assign O_SM_DATA  = row_buf_reg;
    assign O_OUT_VLD  = out_vld_reg;
    assign O_OUT_DATA = res_buf_reg;
    assign O_OUT_IDX  = out_idx_reg;
    assign O_OUT_LAST = out_last_reg;
    assign O_DONE     = done_reg;
    assign O_ERR      = err_reg;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_reg     <= S_IDLE;
            to_cnt_reg    <= '0;
            row_cnt_reg   <= '0;
            timed_out_reg <= 1'b0;
            sm_start_reg  <= 1'b0;
            row_buf_reg   <= '0;
            res_buf_reg   <= '0;
            out_vld_reg   <= 1'b0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (I_ROW_VLD) begin
                        row_buf_reg  <= I_ROW_DATA;
                        sm_start_reg <= 1'b1;
                        to_cnt_reg   <= '0;
                        state_reg    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // The softmax clears its outputs on the next edge, so the
                    // result is captured in the same cycle as its valid.
                    if (I_SM_VLD) begin
                        res_buf_reg   <= I_SM_DATA;
                        sm_start_reg  <= 1'b0;
                        timed_out_reg <= 1'b0;
                        state_reg     <= S_GAP;
                    end else if (to_cnt_reg == TO_LAST) begin
                        // Row dropped: no output, but its index is consumed.
                        sm_start_reg  <= 1'b0;
                        err_reg       <= 1'b1;
                        row_cnt_reg   <= row_cnt_next;
                        timed_out_reg <= 1'b1;
                        state_reg     <= S_GAP;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 8'd1;
                    end
                end
                S_GAP: begin
                    // One low-start cycle lets the softmax return to idle.
                    state_reg <= timed_out_reg ? S_IDLE : S_OUT;
                end
                S_OUT: begin
                    // First S_OUT cycle loads the registered output view;
                    // afterwards wait for the downstream handshake.
                    if (!out_vld_reg) begin
                        out_vld_reg  <= 1'b1;
                        out_idx_reg  <= row_cnt_reg;
                        out_last_reg <= (row_cnt_reg == LAST_IDX);
                    end else if (I_OUT_RDY) begin
                        out_vld_reg <= 1'b0;
                        row_cnt_reg <= row_cnt_next;
                        done_reg    <= out_last_reg;
                        state_reg   <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_row_seq.sv
// -----------------------------------------------------------------------------
// tb_softmax_row_seq
//
// Drives softmax_row_seq with directed and random rows. A softmax responder
// answers with (input + 1) per element, one cycle of valid, after start has
// been sampled high SM_LAT times. A small model tracks the expected row index
// and error flag.
// -----------------------------------------------------------------------------
module tb_softmax_row_seq;

    localparam int D_W     = 8;
    localparam int NUM     = 16;
    localparam int ROWS    = 16;
    localparam int TIMEOUT = 15;
    localparam int IDX_W   = $clog2(ROWS);
    localparam int W       = NUM * D_W;
    localparam int SM_LAT  = 6;

    logic               I_CLK;
    logic               I_RST_N;
    logic               I_ROW_VLD;
    logic               O_ROW_RDY;
    logic [W-1:0]       I_ROW_DATA;
    logic               O_SM_START;
    logic [W-1:0]       O_SM_DATA;
    logic               I_SM_VLD;
    logic [W-1:0]       I_SM_DATA;
    logic               O_OUT_VLD;
    logic               I_OUT_RDY;
    logic [W-1:0]       O_OUT_DATA;
    logic [IDX_W-1:0]   O_OUT_IDX;
    logic               O_OUT_LAST;
    logic               O_DONE;
    logic               O_ERR;

    softmax_row_seq #(.D_W(D_W), .NUM(NUM), .ROWS(ROWS), .TIMEOUT(TIMEOUT)) dut (
        .I_CLK(I_CLK), .I_RST_N(I_RST_N),
        .I_ROW_VLD(I_ROW_VLD), .O_ROW_RDY(O_ROW_RDY), .I_ROW_DATA(I_ROW_DATA),
        .O_SM_START(O_SM_START), .O_SM_DATA(O_SM_DATA),
        .I_SM_VLD(I_SM_VLD), .I_SM_DATA(I_SM_DATA),
        .O_OUT_VLD(O_OUT_VLD), .I_OUT_RDY(I_OUT_RDY), .O_OUT_DATA(O_OUT_DATA),
        .O_OUT_IDX(O_OUT_IDX), .O_OUT_LAST(O_OUT_LAST),
        .O_DONE(O_DONE), .O_ERR(O_ERR)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int handoffs = 0;
    int last_a  = -1;
    int model_idx = 0;
    bit model_err = 1'b0;

    always @(posedge I_CLK) cyc <= cyc + 1;
    always @(posedge I_CLK)
        if (I_RST_N && O_OUT_VLD && I_OUT_RDY) handoffs <= handoffs + 1;

    // Softmax responder.
    logic         resp_en = 1'b0;
    logic         resp_vld = 1'b0;
    logic [W-1:0] resp_data = '0;
    logic         stray_vld = 1'b0;
    int           hi = 0;

    always @(posedge I_CLK) begin
        #1;
        if (O_SM_START) hi = hi + 1;
        else            hi = 0;
        resp_vld = resp_en && (hi == SM_LAT + 1);
        resp_data = '0;
        if (resp_vld)
            for (int i = 0; i < NUM; i++)
                resp_data[i*D_W +: D_W] = O_SM_DATA[i*D_W +: D_W] + 1'b1;
    end

    assign I_SM_VLD  = resp_vld | stray_vld;
    assign I_SM_DATA = stray_vld ? {NUM{8'hA5}} : resp_data;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < NUM; i++) r[i*D_W +: D_W] = D_W'($urandom);
        return r;
    endfunction

    function automatic logic [W-1:0] plus_one(input logic [W-1:0] r);
        logic [W-1:0] e;
        for (int i = 0; i < NUM; i++) e[i*D_W +: D_W] = r[i*D_W +: D_W] + 1'b1;
        return e;
    endfunction

    task automatic start_row(input string tag, input logic [W-1:0] row, output int a);
        int k = 0;
        while (!O_ROW_RDY && k < 60) begin
            @(posedge I_CLK); #1;
            k++;
        end
        check({tag, "_row_rdy"}, O_ROW_RDY, 1'b1);
        I_ROW_DATA = row;
        I_ROW_VLD  = 1'b1;
        @(posedge I_CLK); #1;
        a = cyc;
        I_ROW_VLD = 1'b0;
    endtask

    // One row end to end; bp = cycles of downstream backpressure.
    task automatic do_row(input string tag, input logic [W-1:0] row, input bit resp_on,
                          input int bp, input bit chk_period);
        int a, hi_cnt, vld_k, h0;
        bit sm_ok, bp_ok, done_seen, back;
        logic [W-1:0] od;
        logic [IDX_W-1:0] oi;
        logic ol;
        bit exp_last;
        resp_en   = resp_on;
        I_OUT_RDY = (bp == 0);
        h0 = handoffs;
        start_row(tag, row, a);
        if (chk_period && last_a >= 0) check({tag, "_period"}, a - last_a, 11);
        last_a = a;
        hi_cnt = O_SM_START ? 1 : 0;
        vld_k = -1; sm_ok = 1; bp_ok = 1; done_seen = 0; back = 0;
        od = '0; oi = '0; ol = 1'b0;
        for (int k = 1; k <= 80 && !back; k++) begin
            I_ROW_DATA = rand_row();
            @(posedge I_CLK); #1;
            if (O_SM_START) begin
                hi_cnt++;
                if (O_SM_DATA !== row) sm_ok = 0;
            end
            if (O_DONE) done_seen = 1;
            if (O_OUT_VLD && vld_k < 0) begin
                vld_k = k; od = O_OUT_DATA; oi = O_OUT_IDX; ol = O_OUT_LAST;
            end else if (vld_k >= 0 && k - vld_k <= bp) begin
                if (!O_OUT_VLD || O_OUT_DATA !== od || O_OUT_IDX !== oi ||
                    O_OUT_LAST !== ol || O_ROW_RDY || O_SM_START) bp_ok = 0;
            end
            if (vld_k >= 0 && k - vld_k >= bp) I_OUT_RDY = 1'b1;
            if (O_ROW_RDY) back = 1;
        end
        check({tag, "_back_idle"}, back, 1'b1);
        check({tag, "_sm_data_stable"}, sm_ok, 1'b1);
        check({tag, "_start_cycles"}, hi_cnt, resp_on ? SM_LAT + 1 : TIMEOUT);
        exp_last = (model_idx == ROWS - 1);
        if (resp_on) begin
            check({tag, "_vld_latency"}, vld_k, SM_LAT + 3);
            check({tag, "_data"}, od, plus_one(row));
            check({tag, "_idx"}, oi, model_idx[IDX_W-1:0]);
            check({tag, "_last"}, ol, exp_last);
            check({tag, "_done"}, done_seen, exp_last);
            check({tag, "_bp_stable"}, bp_ok, 1'b1);
            check({tag, "_handoffs"}, handoffs - h0, 1);
        end else begin
            model_err = 1'b1;
            check({tag, "_no_out_vld"}, vld_k, -1);
            check({tag, "_no_done"}, done_seen, 1'b0);
            check({tag, "_handoffs"}, handoffs - h0, 0);
        end
        check({tag, "_err"}, O_ERR, model_err);
        $display("row %s idx=%0d vld_at=+%0d start_cycles=%0d err=%0b", tag, model_idx, vld_k, hi_cnt, O_ERR);
        model_idx = (model_idx + 1) % ROWS;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rdy"},      O_ROW_RDY,  1'b0);
        check({tag, "_start"},    O_SM_START, 1'b0);
        check({tag, "_sm_data"},  O_SM_DATA,  '0);
        check({tag, "_out_vld"},  O_OUT_VLD,  1'b0);
        check({tag, "_out_data"}, O_OUT_DATA, '0);
        check({tag, "_out_idx"},  O_OUT_IDX,  '0);
        check({tag, "_out_last"}, O_OUT_LAST, 1'b0);
        check({tag, "_done"},     O_DONE,     1'b0);
        check({tag, "_err"},      O_ERR,      1'b0);
    endtask

    initial begin
        logic [W-1:0] ramp;
        int a, k;
        I_RST_N = 1'b0; I_ROW_VLD = 1'b0; I_ROW_DATA = '0; I_OUT_RDY = 1'b1;

        // Reset values
        repeat (3) @(posedge I_CLK);
        #1 check_zero("reset");
        @(negedge I_CLK) I_RST_N = 1'b1;
        @(posedge I_CLK); #1;

        // Single ramp row
        for (int i = 0; i < NUM; i++) ramp[i*D_W +: D_W] = D_W'(i);
        do_row("single", ramp, 1'b1, 0, 1'b0);

        // Stray softmax valid while idle
        stray_vld = 1'b1;
        repeat (2) @(posedge I_CLK);
        #1 stray_vld = 1'b0;
        k = 0;
        repeat (5) begin
            @(posedge I_CLK); #1;
            if (O_OUT_VLD || O_SM_START || !O_ROW_RDY) k++;
        end
        check("stray_ignored", k, 0);
        $display("stray sm_vld in idle, disturbances=%0d", k);

        // Back-to-back rows through a matrix boundary
        last_a = -1;
        for (int r = 0; r < ROWS + 1; r++) do_row("b2b", rand_row(), 1'b1, 0, 1'b1);

        // Backpressure
        do_row("bp", rand_row(), 1'b1, 20, 1'b0);

        // Timeout, then a normal row
        do_row("timeout", rand_row(), 1'b0, 0, 1'b0);
        do_row("after_tmo", rand_row(), 1'b1, 0, 1'b0);

        // Reset in S_RUN
        resp_en = 1'b1; I_OUT_RDY = 1'b1;
        start_row("rst_run", rand_row(), a);
        repeat (3) @(posedge I_CLK);
        #2 I_RST_N = 1'b0;
        #1 check_zero("rst_run");
        $display("reset asserted during run");
        @(negedge I_CLK) I_RST_N = 1'b1;
        model_idx = 0; model_err = 1'b0;

        // Reset in S_OUT
        do_row("pre_rst_out", rand_row(), 1'b1, 0, 1'b0);
        I_OUT_RDY = 1'b0;
        start_row("rst_out", rand_row(), a);
        k = 0;
        while (!O_OUT_VLD && k < 40) begin
            @(posedge I_CLK); #1;
            k++;
        end
        check("rst_out_vld_seen", O_OUT_VLD, 1'b1);
        #2 I_RST_N = 1'b0;
        #1 check_zero("rst_out");
        $display("reset asserted during output");
        @(negedge I_CLK) I_RST_N = 1'b1;
        model_idx = 0; model_err = 1'b0;
        do_row("post_rst", rand_row(), 1'b1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
